// File: rtl/player_action_encoder_pkg.sv
// rtl/player_action_encoder_pkg.sv - shared game definitions: action codes, 2-bit constants, cooldown types.
// Reused unchanged by every player block that consumes the action bus.
package player_action_encoder_pkg;

   localparam logic [5:0] ACT_NONE     = 6'b000000;
   localparam logic [5:0] ACT_GO_RIGHT = 6'b100000;
   localparam logic [5:0] ACT_GO_LEFT  = 6'b010000;
   localparam logic [5:0] ACT_WAIT     = 6'b001000;
   localparam logic [5:0] ACT_JUMP     = 6'b000100;
   localparam logic [5:0] ACT_KICK     = 6'b000010;
   localparam logic [5:0] ACT_PUNCH    = 6'b000001;

   // Location/health levels shared with the player blocks.
   localparam logic [1:0] ZERO  = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] TWO   = 2'd2;
   localparam logic [1:0] THREE = 2'd3;

   // Buttons that create sticky edge events; wait is level-sampled instead.
   localparam logic [5:0] EDGE_MASK = 6'b110111;

   typedef enum logic {
      ST_READY    = 1'b0,
      ST_COOLDOWN = 1'b1
   } cooldown_state_t;

   function automatic int cd_width(input int n);
      return (n > 0) ? $clog2(n + 1) : 1;
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - 2-flop synchronizer plus stability counter for one raw button.
// The output flips after DEBOUNCE_CYCLES consecutive synchronized samples disagree with it.
module button_debouncer
   import player_action_encoder_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn,
   output logic o_deb
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0]    r_sync;
   logic [CW-1:0] r_cnt;
   logic          r_deb;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= 2'b00;
         r_cnt  <= '0;
         r_deb  <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], i_btn};
         if (r_sync[1] != r_deb) begin
            if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
               r_deb <= r_sync[1];
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign o_deb = r_deb;

endmodule

// File: rtl/player_action_encoder.sv
// rtl/player_action_encoder.sv - debounced buttons to one prioritized action per game tick.
// Attacks start a cooldown that blocks punch/kick for COOLDOWN_TICKS ticks.
module player_action_encoder
   import player_action_encoder_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int COOLDOWN_TICKS  = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_tick,
   input  logic [5:0] i_btn,
   output logic [5:0] o_action,
   output logic       o_action_valid,
   output logic       o_attack_ready
);

   localparam int CW = cd_width(COOLDOWN_TICKS);
   localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN_TICKS);

   logic [5:0]      w_deb;
   logic [5:0]      w_rise;
   logic [5:0]      w_sel;
   logic            w_blocked;
   logic            w_attack;
   logic [5:0]      r_deb_prev;
   logic [5:0]      r_pend;
   logic [CW-1:0]   r_count;
   cooldown_state_t r_state;

   for (genvar g = 0; g < 6; g++) begin : g_btn
      button_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .i_clk(i_clk),
         .i_rst(i_rst),
         .i_btn(i_btn[g]),
         .o_deb(w_deb[g])
      );
   end

   assign w_rise = w_deb & ~r_deb_prev & EDGE_MASK;

   // Opposite directions cancel each other and fall through to wait.
   always_comb begin
      w_blocked = (r_state == ST_COOLDOWN);
      w_sel     = ACT_NONE;
      if (!w_blocked && r_pend[0])       w_sel = ACT_PUNCH;
      else if (!w_blocked && r_pend[1])  w_sel = ACT_KICK;
      else if (r_pend[2])                w_sel = ACT_JUMP;
      else if (r_pend[4] && !r_pend[5])  w_sel = ACT_GO_LEFT;
      else if (r_pend[5] && !r_pend[4])  w_sel = ACT_GO_RIGHT;
      else if (w_deb[3])                 w_sel = ACT_WAIT;
   end

   assign w_attack = w_sel[0] | w_sel[1];

   // Edges seen in a tick cycle survive the clear and wait for the next tick.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_deb_prev     <= '0;
         r_pend         <= '0;
         r_count        <= '0;
         r_state        <= ST_READY;
         o_action       <= ACT_NONE;
         o_action_valid <= 1'b0;
      end else begin
         r_deb_prev     <= w_deb;
         o_action_valid <= i_tick;
         if (i_tick) begin
            o_action <= w_sel;
            r_pend   <= w_rise;
            if (w_attack) begin
               r_count <= CD_LOAD;
               r_state <= (COOLDOWN_TICKS == 0) ? ST_READY : ST_COOLDOWN;
            end else if (r_count != '0) begin
               r_count <= r_count - 1'b1;
               if (r_count == CW'(1)) r_state <= ST_READY;
            end
         end else begin
            r_pend <= r_pend | w_rise;
         end
      end
   end

   assign o_attack_ready = (r_count == '0);

endmodule

// File: tb/tb_player_action_encoder.sv
// tb/tb_player_action_encoder.sv - directed scenarios plus random buttons/ticks against a reference model.
module tb_player_action_encoder;

   localparam int D = 4;
   localparam int C = 2;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_tick = 1'b0;
   logic [5:0] i_btn = 6'b0;
   logic [5:0] o_action;
   logic       o_action_valid;
   logic       o_attack_ready;

   int n_total = 0;
   int n_bad   = 0;

   player_action_encoder #(
      .DEBOUNCE_CYCLES(D),
      .COOLDOWN_TICKS(C)
   ) dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_tick(i_tick),
      .i_btn(i_btn),
      .o_action(o_action),
      .o_action_valid(o_action_valid),
      .o_attack_ready(o_attack_ready)
   );

   always #5 i_clk = ~i_clk;

   // Reference model: raw sample history, debounced levels, event set, tick-indexed cooldown.
   logic [5:0] m_hist [0:D];
   logic [5:0] m_deb, m_deb_prev, m_pend, m_action;
   logic       m_valid;
   int         m_tick_num, m_last_attack;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic m_ready();
      return (m_tick_num - m_last_attack) >= C;
   endfunction

   task automatic model_reset();
      for (int k = 0; k <= D; k++) m_hist[k] = 6'b0;
      m_deb = 0; m_deb_prev = 0; m_pend = 0; m_action = 0; m_valid = 0;
      m_tick_num = 0; m_last_attack = -1000;
   endtask

   task automatic model_step(input logic [5:0] btn, input logic tick);
      logic [5:0] rise, nd;
      int t;
      bit blocked, same;
      rise = m_deb & ~m_deb_prev;
      rise[3] = 1'b0;
      m_valid = tick;
      if (tick) begin
         t = m_tick_num + 1;
         blocked = (t - m_last_attack) <= C;
         if (!blocked && m_pend[0])                 m_action = 6'b000001;
         else if (!blocked && m_pend[1])            m_action = 6'b000010;
         else if (m_pend[2])                        m_action = 6'b000100;
         else if (m_pend[4] != m_pend[5])           m_action = m_pend[4] ? 6'b010000 : 6'b100000;
         else if (m_deb[3])                         m_action = 6'b001000;
         else                                       m_action = 6'b000000;
         if (m_action == 6'b000001 || m_action == 6'b000010) m_last_attack = t;
         m_tick_num = t;
         m_pend = rise;
      end else begin
         m_pend = m_pend | rise;
      end
      // A level is accepted once the last D synchronized samples all agree and differ from it.
      nd = m_deb;
      for (int b = 0; b < 6; b++) begin
         same = 1;
         for (int k = 2; k <= D; k++) if (m_hist[k][b] != m_hist[1][b]) same = 0;
         if (same && m_hist[1][b] != m_deb[b]) nd[b] = m_hist[1][b];
      end
      m_deb_prev = m_deb;
      m_deb = nd;
      for (int k = D; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = btn;
   endtask

   task automatic cycle(input logic [5:0] btn, input logic tick);
      i_btn = btn;
      i_tick = tick;
      model_step(btn, tick);
      @(posedge i_clk);
      @(negedge i_clk);
      check("action", o_action, m_action);
      check("action_valid", o_action_valid, m_valid);
      check("attack_ready", o_attack_ready, m_ready());
   endtask

   task automatic run(input logic [5:0] btn, input logic tick, input int n);
      for (int k = 0; k < n; k++) cycle(btn, tick);
   endtask

   task automatic press_tick(input logic [5:0] btn);
      run(btn, 1'b0, 10);
      run(6'b0, 1'b0, 3);
      cycle(6'b0, 1'b1);
   endtask

   task automatic do_reset(input string tag);
      i_rst = 1'b1;
      i_tick = 1'b0;
      #1;
      check({tag, "_rst_action"}, o_action, 6'b0);
      check({tag, "_rst_valid"}, o_action_valid, 1'b0);
      check({tag, "_rst_ready"}, o_attack_ready, 1'b1);
      model_reset();
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   logic [5:0] rb;
   logic       rt;

   initial begin
      model_reset();
      @(negedge i_clk);
      do_reset("init");

      // Single punch: emitted once, cooldown engaged.
      press_tick(6'b000001);
      check("punch_action", o_action, 6'b000001);
      check("punch_valid", o_action_valid, 1'b1);
      check("punch_ready", o_attack_ready, 1'b0);
      cycle(6'b0, 1'b0);
      check("punch_valid_drop", o_action_valid, 1'b0);

      // Priority and cooldown sequence.
      do_reset("cd");
      press_tick(6'b000101);
      check("pj_action", o_action, 6'b000001);
      press_tick(6'b000001);
      check("cd_block1", o_action, 6'b000000);
      press_tick(6'b000001);
      check("cd_block2", o_action, 6'b000000);
      press_tick(6'b000001);
      check("cd_accept", o_action, 6'b000001);

      // Left+right cancel, wait held through the tick.
      run(6'b111000, 1'b0, 10);
      run(6'b001000, 1'b0, 3);
      cycle(6'b001000, 1'b1);
      check("lr_cancel_wait", o_action, 6'b001000);
      cycle(6'b001000, 1'b1);
      check("wait_again", o_action, 6'b001000);

      // Short kick glitches never debounce.
      for (int k = 0; k < 3; k++) begin
         run(6'b000010, 1'b0, 2);
         run(6'b000000, 1'b0, 2);
      end
      run(6'b0, 1'b0, 6);
      cycle(6'b0, 1'b1);
      check("glitch_none", o_action, 6'b000000);

      // Kick edge coincides with a tick: deferred to the following tick.
      run(6'b000010, 1'b0, 6);
      cycle(6'b000010, 1'b1);
      check("edge_tick_none", o_action, 6'b000000);
      run(6'b000010, 1'b0, 3);
      cycle(6'b000010, 1'b1);
      check("edge_tick_kick", o_action, 6'b000010);

      // Reset mid-cooldown with jump pending discards everything.
      run(6'b000100, 1'b0, 10);
      run(6'b0, 1'b0, 3);
      do_reset("mid");
      run(6'b0, 1'b0, 3);
      cycle(6'b0, 1'b1);
      check("post_rst_tick", o_action, 6'b000000);

      // Random buttons and ticks with occasional resets.
      rb = 6'b0;
      for (int c = 0; c < 4000; c++) begin
         for (int b = 0; b < 6; b++)
            if ($urandom_range(0, 11) == 0) rb[b] = ~rb[b];
         rt = ($urandom_range(0, 6) == 0);
         if ($urandom_range(0, 999) == 0) do_reset("rnd");
         cycle(rb, rt);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
